// File: rtl/button_debounce.sv
// Purpose : synchronise and debounce raw push-buttons, emit clean levels and press/release/long events.
// Latency : stable raw edge -> btn_level/btn_press/btn_release after DEBOUNCE_CYCLES+2 clk edges.
// Backpressure: none; pure level/pulse outputs, every event is a single-cycle pulse with no handshake.
//
// Ports:
//   clk          system clock; all outputs are in this domain
//   rst_n        asynchronous reset, active-low
//   btn_raw      raw asynchronous button pins (NUM_BTN wide)
//   btn_level    debounced pressed level, 1 = pressed
//   btn_press    1-cycle pulse on accepted press (and on each auto-repeat)
//   btn_release  1-cycle pulse on accepted release
//   btn_long     1-cycle pulse when a hold reaches LONG_CYCLES
//
// Build option: define BUTTON_REPEAT_EN to enable auto-repeat of btn_press
// every REPEAT_CYCLES while a button is held past the long-press point.

module button_debounce #(
    parameter int NUM_BTN         = 2,
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter int LONG_CYCLES     = 27000000,
    parameter int REPEAT_CYCLES   = 5400000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_long
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(LONG_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
    // Pin level seen while the button is not pressed.
    localparam logic IDLE_PIN = ACTIVE_LOW ? 1'b1 : 1'b0;

    generate
        if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
            $error("button_debounce: DEBOUNCE_CYCLES must be >= 1");
        end
        if (LONG_CYCLES < 2) begin : g_bad_long
            $error("button_debounce: LONG_CYCLES must be >= 2");
        end
        if (REPEAT_CYCLES < 1) begin : g_bad_rep
            $error("button_debounce: REPEAT_CYCLES must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HELD = 2'd1,
        ST_LONG = 2'd2
    } state_e;

    // ------------------------------------------------------------------
    // Two-flop synchroniser, preset to the released pin level so reset
    // never looks like a press.
    // ------------------------------------------------------------------
    logic [NUM_BTN-1:0] sync1_q;
    logic [NUM_BTN-1:0] sync2_q;
    logic [NUM_BTN-1:0] pressed_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= {NUM_BTN{IDLE_PIN}};
            sync2_q <= {NUM_BTN{IDLE_PIN}};
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    assign pressed_s = ACTIVE_LOW ? ~sync2_q : sync2_q;

    // ------------------------------------------------------------------
    // Per-channel debounce counter, hold FSM and registered event pulses.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        logic [DW-1:0] deb_cnt_q, deb_cnt_d;
        logic [HW-1:0] hold_cnt_q, hold_cnt_d;
        logic          level_q, level_d;
        logic          press_q, press_d;
        logic          release_q, release_d;
        logic          long_q, long_d;
        state_e        state_q, state_d;
        logic          rise, fall;
`ifdef BUTTON_REPEAT_EN
        localparam int RW = $clog2(REPEAT_CYCLES + 1);
        localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
        logic [RW-1:0] rep_cnt_q, rep_cnt_d;
`endif

        always_comb begin
            deb_cnt_d  = deb_cnt_q;
            hold_cnt_d = hold_cnt_q;
            level_d    = level_q;
            state_d    = state_q;
            press_d    = 1'b0;
            release_d  = 1'b0;
            long_d     = 1'b0;
            rise       = 1'b0;
            fall       = 1'b0;
`ifdef BUTTON_REPEAT_EN
            rep_cnt_d  = rep_cnt_q;
`endif

            // Accept a change only on the DEBOUNCE_CYCLES-th consecutive
            // differing sample; any agreeing sample restarts the count.
            if (pressed_s[i] != level_q) begin
                if (deb_cnt_q == DEB_LAST) begin
                    level_d   = pressed_s[i];
                    deb_cnt_d = '0;
                    rise      = pressed_s[i];
                    fall      = ~pressed_s[i];
                end else begin
                    deb_cnt_d = deb_cnt_q + DW'(1);
                end
            end else begin
                deb_cnt_d = '0;
            end

            // The FSM reacts to the accepted change on the same edge that
            // btn_level moves, so pulses line up with the level.
            case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        state_d    = ST_HELD;
                        hold_cnt_d = '0;
                        press_d    = 1'b1;
                    end
                end
                ST_HELD: begin
                    if (fall) begin
                        state_d   = ST_IDLE;
                        release_d = 1'b1;
                    end else if (hold_cnt_q == HOLD_LAST) begin
                        state_d    = ST_LONG;
                        hold_cnt_d = hold_cnt_q + HW'(1);
                        long_d     = 1'b1;
`ifdef BUTTON_REPEAT_EN
                        rep_cnt_d  = '0;
`endif
                    end else begin
                        hold_cnt_d = hold_cnt_q + HW'(1);
                    end
                end
                ST_LONG: begin
                    // Hold counter stays parked at LONG_CYCLES here, so
                    // btn_long cannot fire a second time in one hold.
                    if (fall) begin
                        state_d   = ST_IDLE;
                        release_d = 1'b1;
                    end
`ifdef BUTTON_REPEAT_EN
                    else if (rep_cnt_q == REP_LAST) begin
                        rep_cnt_d = '0;
                        press_d   = 1'b1;
                    end else begin
                        rep_cnt_d = rep_cnt_q + RW'(1);
                    end
`endif
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                deb_cnt_q  <= '0;
                hold_cnt_q <= '0;
                level_q    <= 1'b0;
                press_q    <= 1'b0;
                release_q  <= 1'b0;
                long_q     <= 1'b0;
                state_q    <= ST_IDLE;
`ifdef BUTTON_REPEAT_EN
                rep_cnt_q  <= '0;
`endif
            end else begin
                deb_cnt_q  <= deb_cnt_d;
                hold_cnt_q <= hold_cnt_d;
                level_q    <= level_d;
                press_q    <= press_d;
                release_q  <= release_d;
                long_q     <= long_d;
                state_q    <= state_d;
`ifdef BUTTON_REPEAT_EN
                rep_cnt_q  <= rep_cnt_d;
`endif
            end
        end

        assign btn_level[i]   = level_q;
        assign btn_press[i]   = press_q;
        assign btn_release[i] = release_q;
        assign btn_long[i]    = long_q;
    end

endmodule

// File: tb/tb_button_debounce.sv
// Purpose : directed self-checking bench for button_debounce with short debounce/hold periods.
// Latency : checks exact edge positions of level changes and pulses against hand-computed counts.
// Backpressure: not applicable; stimulus is free-running button pin levels.

module tb_button_debounce;

    localparam int NB  = 2;
    localparam int DEB = 4;
    localparam int LNG = 20;
    localparam int REP = 6;
`ifdef BUTTON_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_release;
    logic [NB-1:0] btn_long;

    int n_cmp = 0;
    int n_err = 0;

    button_debounce #(
        .NUM_BTN        (NB),
        .DEBOUNCE_CYCLES(DEB),
        .LONG_CYCLES    (LNG),
        .REPEAT_CYCLES  (REP),
        .ACTIVE_LOW     (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_long   (btn_long)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n clock edges and land 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] all_outs();
        return {24'd0, btn_level, btn_press, btn_release, btn_long};
    endfunction

    initial begin
        rst_n   = 1'b0;
        btn_raw = 2'b11;
        step(3);
        chk_eq("rst_outs", all_outs(), 32'd0);
        rst_n = 1'b1;
        step(3);
        chk_eq("post_rst_idle", all_outs(), 32'd0);

        // Press btn 0: level and press move on the 6th edge after the pin edge.
        btn_raw[0] = 1'b0;
        step(5);
        chk_eq("t1_level_early", btn_level, 2'b00);
        chk_eq("t1_press_early", btn_press, 2'b00);
        step(1);
        chk_eq("t1_level", btn_level, 2'b01);
        chk_eq("t1_press", btn_press, 2'b01);
        chk_eq("t1_release", btn_release, 2'b00);
        chk_eq("t1_long", btn_long, 2'b00);
        step(1);
        chk_eq("t1_press_one_cycle", btn_press, 2'b00);
        chk_eq("t1_level_held", btn_level, 2'b01);

        // Long press lands 20 edges after the press pulse.
        step(18);
        chk_eq("t3_long_early", btn_long, 2'b00);
        step(1);
        chk_eq("t3_long", btn_long, 2'b01);
        chk_eq("t3_long_no_press", btn_press, 2'b00);

        // Keep holding 40 cycles: repeats every 6 cycles only in repeat build.
        for (int c = 1; c <= 40; c++) begin
            step(1);
            chk_eq("t4_repeat_press", btn_press, (REP_EN && (c % REP == 0)) ? 2'b01 : 2'b00);
            chk_eq("t4_long_once", btn_long, 2'b00);
            chk_eq("t4_level", btn_level, 2'b01);
        end

        // Release: fall accepted 6 edges after the pin rises.
        btn_raw[0] = 1'b1;
        for (int c = 41; c <= 46; c++) begin
            step(1);
            chk_eq("t3_rel_press", btn_press, (REP_EN && (c % REP == 0) && c < 46) ? 2'b01 : 2'b00);
            chk_eq("t3_release", btn_release, (c == 46) ? 2'b01 : 2'b00);
            chk_eq("t3_rel_level", btn_level, (c < 46) ? 2'b01 : 2'b00);
        end
        step(1);
        chk_eq("t3_idle_after_rel", all_outs(), 32'd0);

        // Glitch of 3 cycles must be rejected.
        btn_raw[0] = 1'b0;
        step(3);
        btn_raw[0] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step(1);
            chk_eq("t2_glitch", all_outs(), 32'd0);
        end

        // Both buttons together, then release btn 1 only.
        btn_raw = 2'b00;
        step(6);
        chk_eq("t5_press_both", btn_press, 2'b11);
        chk_eq("t5_level_both", btn_level, 2'b11);
        step(1);
        chk_eq("t5_press_clear", btn_press, 2'b00);
        btn_raw = 2'b10;
        step(6);
        chk_eq("t5_release_b1", btn_release, 2'b10);
        chk_eq("t5_level_b0", btn_level, 2'b01);
        chk_eq("t5_no_press", btn_press, 2'b00);
        step(1);
        chk_eq("t5_release_clear", btn_release, 2'b00);
        step(11);
        chk_eq("t5_long_early", btn_long, 2'b00);
        step(1);
        chk_eq("t5_long_b0", btn_long, 2'b01);
        step(2);

        // Reset while in LONG, button still held through reset release.
        rst_n = 1'b0;
        #1;
        chk_eq("t6_rst_immediate", all_outs(), 32'd0);
        step(2);
        chk_eq("t6_rst_held", all_outs(), 32'd0);
        rst_n = 1'b1;
        step(5);
        chk_eq("t6_level_early", btn_level, 2'b00);
        chk_eq("t6_press_early", btn_press, 2'b00);
        step(1);
        chk_eq("t6_press", btn_press, 2'b01);
        chk_eq("t6_level", btn_level, 2'b01);
        step(19);
        chk_eq("t6_long_early", btn_long, 2'b00);
        step(1);
        chk_eq("t6_long", btn_long, 2'b01);
        step(1);
        chk_eq("t6_long_one_cycle", btn_long, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
